// File: rtl/reg_pkg.sv
// Shared types for the 32-entry register bank and its write-back queue.
// Register 0 is never stored; addresses index the full 32-entry space.
package reg_pkg;

    localparam int WIDTH = 32;
    localparam int SIZE  = 5;
    localparam int NREGS = 32;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SIZE-1:0]  addr_t;

    typedef struct packed {
        addr_t addr;
        word_t data;
    } wb_entry_t;

    function automatic logic [NREGS-1:0] onehot(input addr_t a);
        return NREGS'(1) << a;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back queue; exposes every slot's valid/addr so the
// register bank can flag registers with writes still in flight.
module wb_fifo
    import reg_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  wb_entry_t        entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [DEPTH-1:0] ent_valid_o,
    output addr_t            ent_addr_o [DEPTH]
);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off            = PW'(i) - rd_ptr_q;
        assign ent_valid_o[i] = ({1'b0, off} < count_q);
        assign ent_addr_o[i]  = mem_q[i].addr;
    end

endmodule

// File: rtl/reg_bank_wb.sv
// 32-entry register bank fed by a buffered write-back port; commits one
// queued write per cycle and publishes per-register pending-write flags.
module reg_bank_wb
    import reg_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  addr_t            wr_addr,
    input  word_t            wr_data,
    output word_t            data [0:NREGS-1],
    output logic [NREGS-1:0] busy_vec,
    output logic             commit_valid,
    output addr_t            commit_addr
);

    wb_entry_t        head;
    wb_entry_t        entry_in;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [DEPTH-1:0] ent_valid;
    addr_t            ent_addr [DEPTH];
    logic             push;
    logic             pop;
    logic [NREGS-1:0] busy;

    word_t regs_q [1:NREGS-1];
    logic  commit_valid_q;
    addr_t commit_addr_q;

    assign wr_ready = (fifo_count < CW'(DEPTH));

    // Writes to r0 complete the handshake but are dropped here.
    assign push     = wr_valid & ~fifo_full & (wr_addr != '0);
    assign pop      = ~fifo_empty;
    assign entry_in = '{addr: wr_addr, data: wr_data};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .entry_i    (entry_in),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .ent_valid_o(ent_valid),
        .ent_addr_o (ent_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            commit_valid_q <= 1'b0;
            commit_addr_q  <= '0;
        end else begin
            commit_valid_q <= pop;
            if (pop) begin
                commit_addr_q <= head.addr;
                for (int i = 1; i < NREGS; i++) begin
                    if (head.addr == addr_t'(i)) begin
                        regs_q[i] <= head.data;
                    end
                end
            end
        end
    end

    always_comb begin
        data[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            data[i] = regs_q[i];
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                busy = busy | onehot(ent_addr[i]);
            end
        end
        busy[0] = 1'b0;
    end

    assign busy_vec     = busy;
    assign commit_valid = commit_valid_q;
    assign commit_addr  = commit_addr_q;

endmodule
